// File: rtl/ysyx_23060077_riscv_ifu_if.sv
// ysyx_23060077_riscv_ifu_if: redirect, instruction-memory and decoder-side signals of the IFU
interface ysyx_23060077_riscv_ifu_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_fault;
    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data,
               imem_rsp_err, if_ready,
        output imem_req_valid, imem_req_addr, if_valid, if_inst, if_pc, if_fault
    );
    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data,
               imem_rsp_err, if_ready,
        input  imem_req_valid, imem_req_addr, if_valid, if_inst, if_pc, if_fault
    );
endinterface

// File: rtl/ysyx_23060077_riscv_ifu.sv
// ysyx_23060077_riscv_ifu: single-outstanding instruction fetch unit with redirect squash
// RISCV_IFU_ALIGN_CHECK_EN reports misaligned redirect targets as fault entries.
module ysyx_23060077_riscv_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input logic clk,
    input logic rst,
    ysyx_23060077_riscv_ifu_if.master bus
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, HOLD = 2'd3;
    logic [1:0]  state;
    logic [31:0] pc, req_addr, rpc;
    logic        drop, mis, mis_r, in_flight;
`ifdef RISCV_IFU_ALIGN_CHECK_EN
    assign rpc   = bus.redirect_pc;
    assign mis_r = |bus.redirect_pc[1:0];
`else
    assign rpc   = bus.redirect_pc & 32'hFFFF_FFFC;
    assign mis_r = 1'b0;
`endif
    assign bus.imem_req_valid = state == REQ;
    assign bus.imem_req_addr  = req_addr;
    // a redirect must drain an outstanding or pending bus transaction before acting
    assign in_flight = state == REQ || (state == WAIT && !bus.imem_rsp_valid);
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            req_addr     <= RESET_PC;
            drop         <= 1'b0;
            mis          <= 1'b0;
            bus.if_valid <= 1'b0;
            bus.if_inst  <= 32'h0;
            bus.if_pc    <= 32'h0;
            bus.if_fault <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc <= rpc;
            if (in_flight) begin
                drop <= 1'b1;
                mis  <= mis_r;
                if (state == REQ && bus.imem_req_ready) state <= WAIT;
            end else begin
                drop         <= 1'b0;
                mis          <= 1'b0;
                req_addr     <= rpc;
                bus.if_valid <= mis_r;
                state        <= mis_r ? HOLD : REQ;
                if (mis_r) begin
                    bus.if_inst  <= 32'h0;
                    bus.if_pc    <= rpc;
                    bus.if_fault <= 1'b1;
                end
            end
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ:  if (bus.imem_req_ready) state <= WAIT;
                WAIT: if (bus.imem_rsp_valid) begin
                    if (!drop) begin
                        bus.if_inst  <= bus.imem_rsp_data;
                        bus.if_pc    <= req_addr;
                        bus.if_fault <= bus.imem_rsp_err;
                        bus.if_valid <= 1'b1;
                        pc           <= req_addr + 32'd4;
                        state        <= HOLD;
                    end else if (mis) begin
                        drop         <= 1'b0;
                        mis          <= 1'b0;
                        bus.if_inst  <= 32'h0;
                        bus.if_pc    <= pc;
                        bus.if_fault <= 1'b1;
                        bus.if_valid <= 1'b1;
                        state        <= HOLD;
                    end else begin
                        drop     <= 1'b0;
                        req_addr <= pc;
                        state    <= REQ;
                    end
                end
                default: if (bus.if_valid && bus.if_ready) begin
                    bus.if_valid <= 1'b0;
                    req_addr     <= pc;
                    state        <= REQ;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_23060077_riscv_ifu.sv
// tb_ysyx_23060077_riscv_ifu: cycle vector table plus wraparound, reset and alignment sequences
module tb_ysyx_23060077_riscv_ifu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0, fails = 0;
    always #5 clk = ~clk;
    ysyx_23060077_riscv_ifu_if bus ();
    ysyx_23060077_riscv_ifu dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rr, sv;
        logic [31:0] sd;
        logic        se, ir;
        logic        e_rq;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst, e_pc;
        logic        e_f;
    } vec_t;
    vec_t tbl[32];
    function automatic vec_t mk(logic rv, logic [31:0] rpc, logic rr, logic sv, logic [31:0] sd,
                                logic se, logic ir, logic e_rq, logic [31:0] e_addr, logic e_iv,
                                logic [31:0] e_inst, logic [31:0] e_pc, logic e_f);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rr = rr; v.sv = sv; v.sd = sd; v.se = se; v.ir = ir;
        v.e_rq = e_rq; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst; v.e_pc = e_pc; v.e_f = e_f;
        return v;
    endfunction
    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask
    task automatic drive(input logic rv, input logic [31:0] rpc, input logic rr, input logic sv,
                         input logic [31:0] sd, input logic se, input logic ir);
        bus.redirect_valid = rv; bus.redirect_pc = rpc; bus.imem_req_ready = rr;
        bus.imem_rsp_valid = sv; bus.imem_rsp_data = sd; bus.imem_rsp_err = se; bus.if_ready = ir;
    endtask
    initial begin
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 0, 0, 0, 0, 1, 32'h8000_0000, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 1, 32'h0000_0013, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0000_0013, 32'h8000_0000, 0);
        tbl[4]  = mk(0, 0, 1, 0, 0, 0, 0, 1, 32'h8000_0004, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 1, 32'h0010_0093, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 6; i <= 10; i++)
            tbl[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0010_0093, 32'h8000_0004, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0010_0093, 32'h8000_0004, 0);
        tbl[12] = mk(0, 0, 1, 0, 0, 0, 0, 1, 32'h8000_0008, 0, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 1, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'hDEAD_BEEF, 32'h8000_0008, 1);
        tbl[15] = mk(0, 0, 1, 0, 0, 0, 0, 1, 32'h8000_000C, 0, 0, 0, 0);
        tbl[16] = mk(1, 32'h8000_0100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[17] = mk(0, 0, 0, 1, 32'h1111_1111, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0100, 0, 0, 0, 0);
        tbl[19] = mk(1, 32'h8000_0200, 0, 0, 0, 0, 0, 1, 32'h8000_0100, 0, 0, 0, 0);
        tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0100, 0, 0, 0, 0);
        tbl[21] = mk(0, 0, 1, 0, 0, 0, 0, 1, 32'h8000_0100, 0, 0, 0, 0);
        tbl[22] = mk(0, 0, 0, 1, 32'h2222_2222, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[23] = mk(0, 0, 1, 0, 0, 0, 0, 1, 32'h8000_0200, 0, 0, 0, 0);
        tbl[24] = mk(0, 0, 0, 1, 32'h3333_3333, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[25] = mk(1, 32'h8000_0300, 0, 0, 0, 0, 1, 0, 0, 1, 32'h3333_3333, 32'h8000_0200, 0);
        tbl[26] = mk(0, 0, 1, 0, 0, 0, 0, 1, 32'h8000_0300, 0, 0, 0, 0);
        tbl[27] = mk(1, 32'h8000_0400, 0, 1, 32'h4444_4444, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[28] = mk(0, 0, 1, 0, 0, 0, 0, 1, 32'h8000_0400, 0, 0, 0, 0);
        tbl[29] = mk(0, 0, 0, 1, 32'h5555_5555, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[30] = mk(1, 32'h8000_0102, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5555_5555, 32'h8000_0400, 0);
`ifdef RISCV_IFU_ALIGN_CHECK_EN
        tbl[31] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h8000_0102, 1);
`else
        tbl[31] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0100, 0, 0, 0, 0);
`endif
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_req_valid", 0, {31'h0, bus.imem_req_valid}, 32'h0);
        chk("reset_if_valid", 0, {31'h0, bus.if_valid}, 32'h0);
        chk("reset_if_inst", 0, bus.if_inst, 32'h0);
        chk("reset_if_pc", 0, bus.if_pc, 32'h0);
        chk("reset_if_fault", 0, {31'h0, bus.if_fault}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            drive(tbl[i].rv, tbl[i].rpc, tbl[i].rr, tbl[i].sv, tbl[i].sd, tbl[i].se, tbl[i].ir);
            chk("req_valid", i, {31'h0, bus.imem_req_valid}, {31'h0, tbl[i].e_rq});
            if (tbl[i].e_rq) chk("req_addr", i, bus.imem_req_addr, tbl[i].e_addr);
            chk("if_valid", i, {31'h0, bus.if_valid}, {31'h0, tbl[i].e_iv});
            if (tbl[i].e_iv) begin
                chk("if_inst", i, bus.if_inst, tbl[i].e_inst);
                chk("if_pc", i, bus.if_pc, tbl[i].e_pc);
                chk("if_fault", i, {31'h0, bus.if_fault}, {31'h0, tbl[i].e_f});
            end
            @(negedge clk);
        end
        // PC wraparound, with a stray response in REQ that must be ignored
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("wrap_req_addr", 100, bus.imem_req_addr, 32'hFFFF_FFFC);
        drive(0, 0, 1, 1, 32'h0BAD_0BAD, 0, 0);
        @(negedge clk);
        chk("stray_rsp_if_valid", 101, {31'h0, bus.if_valid}, 32'h0);
        drive(0, 0, 0, 1, 32'h0000_0099, 0, 0);
        @(negedge clk);
        chk("wrap_if_inst", 102, bus.if_inst, 32'h0000_0099);
        chk("wrap_if_pc", 102, bus.if_pc, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("wrap_next_addr", 103, bus.imem_req_addr, 32'h0);
        chk("wrap_next_valid", 103, {31'h0, bus.imem_req_valid}, 32'h1);
        // reset while a response is outstanding
        drive(0, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_req_valid", 104, {31'h0, bus.imem_req_valid}, 32'h0);
        chk("midrst_if_pc", 104, bus.if_pc, 32'h0);
        chk("midrst_if_valid", 104, {31'h0, bus.if_valid}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_req_addr", 105, bus.imem_req_addr, 32'h8000_0000);
        chk("midrst_req_valid2", 105, {31'h0, bus.imem_req_valid}, 32'h1);
`ifdef RISCV_IFU_ALIGN_CHECK_EN
        // misaligned redirect while waiting: drain first, then present the fault entry
        drive(0, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 32'h8000_0102, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("mis_drain_if_valid", 106, {31'h0, bus.if_valid}, 32'h0);
        drive(0, 0, 0, 1, 32'h7777_7777, 0, 0);
        @(negedge clk);
        chk("mis_if_valid", 107, {31'h0, bus.if_valid}, 32'h1);
        chk("mis_if_fault", 107, {31'h0, bus.if_fault}, 32'h1);
        chk("mis_if_pc", 107, bus.if_pc, 32'h8000_0102);
        chk("mis_if_inst", 107, bus.if_inst, 32'h0);
        chk("mis_req_valid", 107, {31'h0, bus.imem_req_valid}, 32'h0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ysyx_23060077_riscv_ifu.md
# ysyx_23060077_riscv_ifu

Instruction fetch unit for the NPC core. It sits directly upstream of the instruction decoder and owns the PC. It fetches one 32-bit instruction at a time over a valid/ready instruction-memory port and presents it, with its PC, on a single-entry valid/ready output register. The decoder consumes `if_inst`. EXU redirects (branch, jump, trap) squash in-flight work.

## Interface
- `RESET_PC`, 32'h8000_0000, PC loaded on reset
- `clk`  in  1  core clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `redirect_valid`  in  1  EXU requests PC change this cycle
- `redirect_pc`  in  32  new fetch target
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  32  fetch address
- `imem_rsp_valid`  in  1  read data valid
- `imem_rsp_data`  in  32  instruction word
- `imem_rsp_err`  in  1  access fault on this response
- `if_valid`  out  1  output entry valid
- `if_ready`  in  1  decoder accepts entry
- `if_inst`  out  32  instruction to decoder
- `if_pc`  out  32  PC of `if_inst`
- `if_fault`  out  1  entry carries a fetch fault

## Operation
- Registers:
  - `pc`
  - `req_addr`
  - `drop` flag
  - output entry (`if_inst`, `if_pc`, `if_fault`, `if_valid`)
  - `state`
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: entered on reset. Always moves to REQ next cycle.
- REQ: `imem_req_valid=1`, `imem_req_addr=req_addr`.
  - Address is held stable until accepted.
  - On `imem_req_ready`, go to WAIT.
- WAIT: on `imem_rsp_valid`:
  - If `drop=0`: load `if_inst=imem_rsp_data`, `if_pc=req_addr`, `if_fault=imem_rsp_err`, `if_valid=1`; set `pc=req_addr+4`; go to HOLD.
  - If `drop=1`: discard the data, clear `drop`, set `req_addr=pc`, go to REQ.
- HOLD: on `if_valid && if_ready`, clear `if_valid`, set `req_addr=pc`, go to REQ.
- Redirect (`redirect_valid=1`) takes priority in every state and always sets `pc=redirect_pc`:
  - IDLE/HOLD: `req_addr=redirect_pc`, `if_valid` cleared, go to REQ. A same-cycle `if_ready` handshake is void; the decoder must ignore `if_valid` while `redirect_valid=1`.
  - REQ, not accepted this cycle: the request stays on the bus unchanged. Set `drop=1`. The response is discarded, then the target is fetched.
  - REQ, accepted this cycle: go to WAIT with `drop=1`.
  - WAIT, no response: `drop=1`.
  - WAIT, same-cycle response: the response is discarded, `req_addr=redirect_pc`, go to REQ.
- PC arithmetic is 32-bit modulo; `32'hFFFF_FFFC + 4` gives `0`.
- `imem_rsp_valid` outside WAIT is ignored.
- `imem_rsp_err` does not stop fetching. The entry is delivered with `if_fault=1`; EXU raises the trap and redirects.

## Timing
- Reset values:
  - `state=IDLE`, `pc=req_addr=RESET_PC`, `drop=0`
  - `if_valid=0`, `if_inst=0`, `if_pc=0`, `if_fault=0`
  - `imem_req_valid=0`
- `imem_req_valid` is combinational from `state==REQ`. It first rises 1 cycle after `rst` deasserts.
- Zero-wait memory (ready in REQ, response the next cycle):
  - REQ→WAIT→HOLD→REQ.
  - `if_valid` rises 2 cycles after request acceptance.
  - Best-case throughput is 1 instruction per 3 cycles.
- Redirect latency: a redirect in HOLD drives `imem_req_addr=redirect_pc` on the next cycle.
- Reset mid-transaction returns to the reset values in 1 cycle. Instruction memory must be reset by the same `rst`; no stale response may arrive after reset.
- No combinational path from any input to `if_*`. `imem_req_*` depends only on registers.

## Configuration
- `RISCV_IFU_ALIGN_CHECK_EN`
  - Defined: a redirect with `redirect_pc[1:0]!=0` issues no bus request. The next cycle it produces an entry with `if_valid=1`, `if_fault=1`, `if_inst=0`, `if_pc=redirect_pc`, state HOLD. Any in-flight response is still drained through `drop`; the entry is presented after the drain.
  - Undefined: `redirect_pc[1:0]` is treated as `2'b00`, and misalignment is never reported.

## Test plan
- Reset release, zero-wait memory returning `32'h0000_0013`: `imem_req_addr=32'h8000_0000` 1 cycle after reset, then `if_inst=32'h0000_0013`, `if_pc=32'h8000_0000`. The next request is at `32'h8000_0004`.
- `if_ready` held low 5 cycles in HOLD: `if_valid` and the entry stay stable. No new `imem_req_valid` until the handshake.
- `redirect_pc=32'h8000_0100` while in WAIT: the pending response is discarded and `if_valid` stays 0. The next request is at `32'h8000_0100`.
- `imem_req_ready` held low 3 cycles with a redirect on the 2nd: `imem_req_addr` is unchanged until accepted, the old response is dropped, then the target is fetched.
- Response with `imem_rsp_err=1` at `32'h8000_0008`: entry has `if_fault=1`, `if_pc=32'h8000_0008`. Fetch continues at `32'h8000_000C`.
- With `RISCV_IFU_ALIGN_CHECK_EN`, redirect to `32'h8000_0102`: entry `if_fault=1`, `if_pc=32'h8000_0102`, no bus request. Without the macro: request at `32'h8000_0100`.
